// File: rtl/otter_arb_pkg.sv
// Shared types and constants for the OTTER memory port-2 arbiter.
// Build option: OTTER_ARB_RR_EN selects round-robin tie breaking.
package otter_arb_pkg;

    typedef enum logic {IDLE, RD_DATA} arb_state_t;
    typedef enum logic {M0, M1} req_id_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam logic [31:0] MMIO_BASE = 32'h0001_0000;

endpackage

// File: rtl/otter_arb_pick.sv
// Combinational winner select between the two requesters.
// OTTER_ARB_RR_EN: round-robin on ties; otherwise M0 has fixed priority.
module otter_arb_pick
    import otter_arb_pkg::*;
(
    input  logic    req0,
    input  logic    req1,
    input  req_id_t last_gnt,
    output logic    any,
    output req_id_t winner
);

    assign any = req0 | req1;

`ifdef OTTER_ARB_RR_EN
    always_comb begin
        winner = M0;
        if (req0 && req1) begin
            winner = (last_gnt == M0) ? M1 : M0;
        end else if (req1) begin
            winner = M1;
        end
    end
`else
    logic unused_last;
    assign unused_last = (last_gnt == M1);

    always_comb begin
        winner = M0;
        if (!req0 && req1) begin
            winner = M1;
        end
    end
`endif

endmodule

// File: rtl/otter_mem_arbiter.sv
// Two-requester arbiter for the OTTER memory data port (port 2).
// Build option: OTTER_ARB_RR_EN (round-robin), default fixed priority.
module otter_mem_arbiter
    import otter_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              M0_REQ,
    input  logic              M0_WE,
    input  logic [ADDR_W-1:0] M0_ADDR,
    input  logic [DATA_W-1:0] M0_DIN,
    input  logic [1:0]        M0_SIZE,
    input  logic              M0_SIGN,
    output logic              M0_GNT,
    output logic              M0_RVALID,
    output logic [DATA_W-1:0] M0_RDATA,
    input  logic              M1_REQ,
    input  logic              M1_WE,
    input  logic [ADDR_W-1:0] M1_ADDR,
    input  logic [DATA_W-1:0] M1_DIN,
    input  logic [1:0]        M1_SIZE,
    input  logic              M1_SIGN,
    output logic              M1_GNT,
    output logic              M1_RVALID,
    output logic [DATA_W-1:0] M1_RDATA,
    output logic              MEM_RDEN2,
    output logic              MEM_WE2,
    output logic [ADDR_W-1:0] MEM_ADDR2,
    output logic [DATA_W-1:0] MEM_DIN2,
    output logic [1:0]        MEM_SIZE,
    output logic              MEM_SIGN,
    input  logic [DATA_W-1:0] MEM_DOUT2
);

    arb_state_t state, state_nxt;
    req_id_t    last_gnt, owner, winner;
    logic       any;

    logic [ADDR_W-1:0] lat_addr;
    logic [1:0]        lat_size;
    logic              lat_sign;

    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_din;
    logic [1:0]        w_size;
    logic              w_sign;

    otter_arb_pick u_pick (
        .req0     (M0_REQ),
        .req1     (M1_REQ),
        .last_gnt (last_gnt),
        .any      (any),
        .winner   (winner)
    );

    always_comb begin
        w_we   = M0_WE;
        w_addr = M0_ADDR;
        w_din  = M0_DIN;
        w_size = M0_SIZE;
        w_sign = M0_SIGN;
        if (winner == M1) begin
            w_we   = M1_WE;
            w_addr = M1_ADDR;
            w_din  = M1_DIN;
            w_size = M1_SIZE;
            w_sign = M1_SIGN;
        end
    end

    always_comb begin
        state_nxt = state;
        M0_GNT    = 1'b0;
        M1_GNT    = 1'b0;
        MEM_RDEN2 = 1'b0;
        MEM_WE2   = 1'b0;
        MEM_ADDR2 = '0;
        MEM_DIN2  = '0;
        MEM_SIZE  = '0;
        MEM_SIGN  = 1'b0;
        unique case (state)
            IDLE: begin
                if (any) begin
                    M0_GNT    = (winner == M0);
                    M1_GNT    = (winner == M1);
                    MEM_WE2   = w_we;
                    MEM_RDEN2 = !w_we;
                    MEM_ADDR2 = w_addr;
                    MEM_DIN2  = w_din;
                    MEM_SIZE  = w_size;
                    MEM_SIGN  = w_sign;
                    if (!w_we) begin
                        state_nxt = RD_DATA;
                    end
                end
            end
            RD_DATA: begin
                // memory sizes read data from these, so hold them
                MEM_ADDR2 = lat_addr;
                MEM_SIZE  = lat_size;
                MEM_SIGN  = lat_sign;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            last_gnt <= M1;
            owner    <= M0;
            lat_addr <= '0;
            lat_size <= '0;
            lat_sign <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && any) begin
                last_gnt <= winner;
                if (!w_we) begin
                    owner    <= winner;
                    lat_addr <= w_addr;
                    lat_size <= w_size;
                    lat_sign <= w_sign;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            M0_RVALID <= 1'b0;
            M1_RVALID <= 1'b0;
            M0_RDATA  <= '0;
            M1_RDATA  <= '0;
        end else begin
            M0_RVALID <= (state == RD_DATA) && (owner == M0);
            M1_RVALID <= (state == RD_DATA) && (owner == M1);
            if (state == RD_DATA) begin
                if (owner == M0) begin
                    M0_RDATA <= MEM_DOUT2;
                end else begin
                    M1_RDATA <= MEM_DOUT2;
                end
            end
        end
    end

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Directed self-checking bench for otter_mem_arbiter with a small
// synchronous-read memory model (sized reads, one MMIO input word).
module tb_otter_mem_arbiter;

`ifdef OTTER_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    localparam logic [31:0] IO_IN = 32'hCAFE_0042;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        M0_REQ = 0, M0_WE = 0, M0_SIGN = 0;
    logic [31:0] M0_ADDR = 0, M0_DIN = 0;
    logic [1:0]  M0_SIZE = 0;
    logic        M1_REQ = 0, M1_WE = 0, M1_SIGN = 0;
    logic [31:0] M1_ADDR = 0, M1_DIN = 0;
    logic [1:0]  M1_SIZE = 0;
    logic        M0_GNT, M0_RVALID, M1_GNT, M1_RVALID;
    logic [31:0] M0_RDATA, M1_RDATA;
    logic        MEM_RDEN2, MEM_WE2, MEM_SIGN;
    logic [31:0] MEM_ADDR2, MEM_DIN2, MEM_DOUT2;
    logic [1:0]  MEM_SIZE;

    int total = 0;
    int bad = 0;

    always #5 CLK = ~CLK;

    otter_mem_arbiter dut (
        .CLK(CLK), .RST(RST),
        .M0_REQ(M0_REQ), .M0_WE(M0_WE), .M0_ADDR(M0_ADDR),
        .M0_DIN(M0_DIN), .M0_SIZE(M0_SIZE), .M0_SIGN(M0_SIGN),
        .M0_GNT(M0_GNT), .M0_RVALID(M0_RVALID), .M0_RDATA(M0_RDATA),
        .M1_REQ(M1_REQ), .M1_WE(M1_WE), .M1_ADDR(M1_ADDR),
        .M1_DIN(M1_DIN), .M1_SIZE(M1_SIZE), .M1_SIGN(M1_SIGN),
        .M1_GNT(M1_GNT), .M1_RVALID(M1_RVALID), .M1_RDATA(M1_RDATA),
        .MEM_RDEN2(MEM_RDEN2), .MEM_WE2(MEM_WE2), .MEM_ADDR2(MEM_ADDR2),
        .MEM_DIN2(MEM_DIN2), .MEM_SIZE(MEM_SIZE), .MEM_SIGN(MEM_SIGN),
        .MEM_DOUT2(MEM_DOUT2)
    );

    // memory model: registered word read, combinational sizing
    logic [31:0] mem [0:255];
    logic [31:0] rd_word = 0;
    int          io_wr_cnt = 0;

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] din,
                                          input logic [1:0]  sz,
                                          input logic [1:0]  off);
        logic [31:0] r;
        r = old;
        case (sz)
            2'd0: r[8*off +: 8] = din[7:0];
            2'd1: r[16*off[1] +: 16] = din[15:0];
            2'd2: r = din;
            default: ;
        endcase
        return r;
    endfunction

    always @(posedge CLK) begin
        if (MEM_WE2) begin
            if (MEM_ADDR2 >= 32'h0001_0000)
                io_wr_cnt <= io_wr_cnt + 1;
            else
                mem[MEM_ADDR2[9:2]] <= merge(mem[MEM_ADDR2[9:2]],
                    MEM_DIN2, MEM_SIZE, MEM_ADDR2[1:0]);
        end
        if (MEM_RDEN2) begin
            if (MEM_ADDR2 >= 32'h0001_0000)
                rd_word <= IO_IN;
            else
                rd_word <= mem[MEM_ADDR2[9:2]];
        end
    end

    logic [31:0] sh;
    always_comb begin
        sh = rd_word >> (8 * MEM_ADDR2[1:0]);
        MEM_DOUT2 = 32'h0;
        case (MEM_SIZE)
            2'd0: MEM_DOUT2 = MEM_SIGN ? {24'h0, sh[7:0]}
                                       : {{24{sh[7]}}, sh[7:0]};
            2'd1: MEM_DOUT2 = MEM_SIGN ? {16'h0, sh[15:0]}
                                       : {{16{sh[15]}}, sh[15:0]};
            2'd2: MEM_DOUT2 = rd_word;
            default: MEM_DOUT2 = 32'h0;
        endcase
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_all();
        M0_REQ = 0; M0_WE = 0;
        M1_REQ = 0; M1_WE = 0;
    endtask

    task automatic test_reset();
        RST = 1;
        @(negedge CLK);
        total++;
        if ({M0_GNT, M1_GNT, M0_RVALID, M1_RVALID} !== 4'b0) begin
            bad++;
            $display("FAIL rst_pulses got=%b exp=0000",
                     {M0_GNT, M1_GNT, M0_RVALID, M1_RVALID});
        end
        total++;
        if ({MEM_RDEN2, MEM_WE2, MEM_ADDR2, MEM_SIZE} !== 36'h0) begin
            bad++;
            $display("FAIL rst_mem got rden=%b we=%b addr=%h size=%0d",
                     MEM_RDEN2, MEM_WE2, MEM_ADDR2, MEM_SIZE);
        end
        total++;
        if (M0_RDATA !== 0 || M1_RDATA !== 0) begin
            bad++;
            $display("FAIL rst_rdata got=%h/%h exp=0", M0_RDATA, M1_RDATA);
        end
        step();
        RST = 0;
        step();
    endtask

    task automatic test_store_load();
        M0_REQ = 1; M0_WE = 1; M0_ADDR = 32'h100;
        M0_DIN = 32'hDEADBEEF; M0_SIZE = 2; M0_SIGN = 0;
        @(negedge CLK);
        total++;
        if (M0_GNT !== 1 || MEM_WE2 !== 1 || MEM_RDEN2 !== 0
            || MEM_SIZE !== 2 || MEM_ADDR2 !== 32'h100) begin
            bad++;
            $display("FAIL st_issue got gnt=%b we=%b rden=%b size=%0d addr=%h",
                     M0_GNT, MEM_WE2, MEM_RDEN2, MEM_SIZE, MEM_ADDR2);
        end
        step();
        M0_WE = 0;
        @(negedge CLK);
        total++;
        if (M0_GNT !== 1 || MEM_RDEN2 !== 1 || MEM_WE2 !== 0) begin
            bad++;
            $display("FAIL ld_issue got gnt=%b rden=%b we=%b exp 1 1 0",
                     M0_GNT, MEM_RDEN2, MEM_WE2);
        end
        step();
        idle_all();
        @(negedge CLK);
        total++;
        if (M0_RVALID !== 0 || M0_GNT !== 0 || MEM_RDEN2 !== 0) begin
            bad++;
            $display("FAIL ld_t1 got rvalid=%b gnt=%b rden=%b exp 0",
                     M0_RVALID, M0_GNT, MEM_RDEN2);
        end
        step();
        @(negedge CLK);
        total++;
        if (M0_RVALID !== 1 || M0_RDATA !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL ld_t2 got rvalid=%b rdata=%h exp 1 deadbeef",
                     M0_RVALID, M0_RDATA);
        end
        step();
        @(negedge CLK);
        total++;
        if (M0_RVALID !== 0) begin
            bad++;
            $display("FAIL ld_pulse got rvalid=%b exp 0", M0_RVALID);
        end
    endtask

    task automatic test_byte_load();
        M1_REQ = 1; M1_WE = 1; M1_ADDR = 32'h103;
        M1_DIN = 32'h80; M1_SIZE = 0; M1_SIGN = 0;
        step();
        M1_WE = 0;
        @(negedge CLK);
        total++;
        if (M1_GNT !== 1 || M0_GNT !== 0) begin
            bad++;
            $display("FAIL bl_gnt got m1=%b m0=%b exp 1 0", M1_GNT, M0_GNT);
        end
        step();
        idle_all();
        @(negedge CLK);
        total++;
        if (MEM_ADDR2 !== 32'h103 || MEM_SIZE !== 0 || MEM_SIGN !== 0
            || MEM_WE2 !== 0) begin
            bad++;
            $display("FAIL bl_hold got addr=%h size=%0d sign=%b we=%b",
                     MEM_ADDR2, MEM_SIZE, MEM_SIGN, MEM_WE2);
        end
        step();
        @(negedge CLK);
        total++;
        if (M1_RVALID !== 1 || M1_RDATA !== 32'hFFFFFF80) begin
            bad++;
            $display("FAIL bl_data got rvalid=%b rdata=%h exp 1 ffffff80",
                     M1_RVALID, M1_RDATA);
        end
        total++;
        if (M0_RVALID !== 0 || M0_RDATA !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL bl_m0hold got rvalid=%b rdata=%h exp 0 deadbeef",
                     M0_RVALID, M0_RDATA);
        end
        step();
    endtask

    task automatic test_contention();
        logic e0, e1;
        M0_REQ = 1; M0_WE = 0; M0_ADDR = 32'h100; M0_SIZE = 2;
        M1_REQ = 1; M1_WE = 0; M1_ADDR = 32'h100; M1_SIZE = 2;
        for (int c = 0; c < 8; c++) begin
            @(negedge CLK);
            e0 = (c % 2 == 0) && (!RR || (c % 4 == 0));
            e1 = (c % 2 == 0) && RR && (c % 4 == 2);
            total++;
            if (M0_GNT !== e0 || M1_GNT !== e1) begin
                bad++;
                $display("FAIL cont_gnt c=%0d got=%b%b exp=%b%b",
                         c, M0_GNT, M1_GNT, e0, e1);
            end
            step();
        end
        idle_all();
        step();
        step();
    endtask

    task automatic test_back_to_back();
        M0_REQ = 1; M0_WE = 0; M0_ADDR = 32'h100; M0_SIZE = 2;
        step();
        M0_REQ = 0;
        M1_REQ = 1; M1_WE = 1; M1_ADDR = 32'h200;
        M1_DIN = 32'h1111_2222; M1_SIZE = 2;
        @(negedge CLK);
        total++;
        if (M1_GNT !== 0 || MEM_WE2 !== 0) begin
            bad++;
            $display("FAIL b2b_rd got gnt=%b we=%b exp 0 0", M1_GNT, MEM_WE2);
        end
        step();
        @(negedge CLK);
        total++;
        if (M0_RVALID !== 1 || M1_GNT !== 1 || MEM_WE2 !== 1
            || MEM_ADDR2 !== 32'h200) begin
            bad++;
            $display("FAIL b2b_gnt got rv=%b gnt=%b we=%b addr=%h",
                     M0_RVALID, M1_GNT, MEM_WE2, MEM_ADDR2);
        end
        step();
        M1_WE = 0;
        step();
        M1_REQ = 0;
        step();
        @(negedge CLK);
        total++;
        if (M1_RVALID !== 1 || M1_RDATA !== 32'h1111_2222) begin
            bad++;
            $display("FAIL b2b_data got rv=%b rdata=%h exp 1 11112222",
                     M1_RVALID, M1_RDATA);
        end
        step();
    endtask

    task automatic test_reset_rd();
        M1_REQ = 1; M1_WE = 0; M1_ADDR = 32'h100; M1_SIZE = 2;
        step();
        idle_all();
        RST = 1;
        @(negedge CLK);
        total++;
        if (MEM_ADDR2 !== 0 || MEM_SIZE !== 0 || MEM_RDEN2 !== 0
            || MEM_WE2 !== 0 || M1_RDATA !== 0) begin
            bad++;
            $display("FAIL rrd_abort got addr=%h size=%0d rdata=%h",
                     MEM_ADDR2, MEM_SIZE, M1_RDATA);
        end
        step();
        RST = 0;
        @(negedge CLK);
        total++;
        if (M1_RVALID !== 0 || M1_RDATA !== 0 || MEM_ADDR2 !== 0) begin
            bad++;
            $display("FAIL rrd_after got rv=%b rdata=%h addr=%h exp 0",
                     M1_RVALID, M1_RDATA, MEM_ADDR2);
        end
        step();
    endtask

    task automatic test_mmio();
        int w0;
        w0 = io_wr_cnt;
        M0_REQ = 1; M0_WE = 1; M0_ADDR = 32'h11000;
        M0_DIN = 32'h55; M0_SIZE = 2;
        @(negedge CLK);
        total++;
        if (M0_GNT !== 1 || MEM_WE2 !== 1 || MEM_ADDR2 !== 32'h11000) begin
            bad++;
            $display("FAIL io_st got gnt=%b we=%b addr=%h",
                     M0_GNT, MEM_WE2, MEM_ADDR2);
        end
        step();
        M0_WE = 0;
        @(negedge CLK);
        total++;
        if (io_wr_cnt - w0 !== 1 || MEM_WE2 !== 0) begin
            bad++;
            $display("FAIL io_wr got writes=%0d we=%b exp 1 0",
                     io_wr_cnt - w0, MEM_WE2);
        end
        step();
        M0_REQ = 0;
        @(negedge CLK);
        total++;
        if (M0_RVALID !== 0) begin
            bad++;
            $display("FAIL io_t1 got rvalid=%b exp 0", M0_RVALID);
        end
        step();
        @(negedge CLK);
        total++;
        if (M0_RVALID !== 1 || M0_RDATA !== IO_IN) begin
            bad++;
            $display("FAIL io_ld got rv=%b rdata=%h exp 1 %h",
                     M0_RVALID, M0_RDATA, IO_IN);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_byte_load();
        test_contention();
        test_back_to_back();
        test_reset_rd();
        test_mmio();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
